// File: rtl/hdb3_line_rx_if.sv
// hdb3_line_rx_if: bundles the bipolar line inputs and decoded outputs of hdb3_line_rx.
//   master: line driver / consumer side (drives line_p/line_n, observes decoded outputs).
//   slave : the receiver itself.
// Optional HDB3_RX_CV_COUNT_EN adds cv_count (receiver -> consumer) and cv_clr (consumer -> receiver).
interface hdb3_line_rx_if;
  logic       line_p;
  logic       line_n;
  logic       bit_data;
  logic       bit_valid;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       cv_err;
  logic       los;
`ifdef HDB3_RX_CV_COUNT_EN
  logic [15:0] cv_count;
  logic        cv_clr;
`endif

  modport master (
    output line_p, line_n,
    input  bit_data, bit_valid, byte_data, byte_valid, cv_err, los
`ifdef HDB3_RX_CV_COUNT_EN
    , input cv_count, output cv_clr
`endif
  );

  modport slave (
    input  line_p, line_n,
    output bit_data, bit_valid, byte_data, byte_valid, cv_err, los
`ifdef HDB3_RX_CV_COUNT_EN
    , output cv_count, input cv_clr
`endif
  );
endinterface

// File: rtl/hdb3_line_rx.sv
// hdb3_line_rx: recovers bit timing from oversampled P/N line pulses, decodes HDB3 to NRZ bits/bytes.
// Latency: bit out 4 bit periods + 1 clk after its mid-bit sample; byte_valid 1 clk after the 8th bit.
// Backpressure: none; outputs are strobes that must be taken when presented.
// Ports: clk, rst (async, active-high); lif (slave modport): line_p/line_n in; bit_data/bit_valid,
//   byte_data/byte_valid, cv_err, los out. Define HDB3_RX_CV_COUNT_EN to add cv_count out / cv_clr in.
module hdb3_line_rx #(
  parameter int OSR      = 8,   // clk samples per line bit, even and >= 4
  parameter int LOS_BITS = 32   // zero symbols before loss of signal, must exceed 3
) (
  input  logic           clk,
  input  logic           rst,
  hdb3_line_rx_if.slave  lif
);
  localparam int             PW      = $clog2(OSR);
  localparam int             ZW      = $clog2(LOS_BITS + 1);
  localparam logic [PW-1:0]  PH_MID  = PW'(OSR / 2);
  localparam logic [PW-1:0]  PH_LAST = PW'(OSR - 1);
  localparam logic [ZW-1:0]  Z_LOS   = ZW'(LOS_BITS);

  logic          p_m, p_s, n_m, n_s, pulse_d;
  logic [PW-1:0] ph;
  logic [3:0]    sym_sr;     // per-entry "symbol was nonzero"; entry 3 is the oldest
  logic [ZW-1:0] zcnt;
  logic          last_pol, last_v_pol, last_v_vld;
  logic [2:0]    bcnt;
  logic [6:0]    byte_sr;
  logic          bit_data_q, bit_valid_q, byte_valid_q, cv_err_q, los_q;
  logic [7:0]    byte_data_q;

  logic pulse, edge_det, strobe;
  logic sym_nz, sym_pos, sym_both, is_v, v_repeat, zrun4, los_set, los_exit;

  // Input synchronisers and edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_m <= 1'b0; p_s <= 1'b0; n_m <= 1'b0; n_s <= 1'b0; pulse_d <= 1'b0;
    end else begin
      p_m <= lif.line_p; p_s <= p_m;
      n_m <= lif.line_n; n_s <= n_m;
      pulse_d <= pulse;
    end
  end

  assign pulse    = p_s | n_s;
  assign edge_det = pulse & ~pulse_d;

  // Phase counter: reload on each pulse edge, free-run across zero symbols
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ph <= '0;
    else if (edge_det)      ph <= PW'(1);
    else if (ph == PH_LAST) ph <= '0;
    else                    ph <= ph + PW'(1);
  end

  assign strobe = (ph == PH_MID);

  // Symbol classification at the sample point
  always_comb begin
    sym_nz   = p_s ^ n_s;
    sym_pos  = p_s;
    sym_both = p_s & n_s;
    // The symbol that ends LOS is taken as an ordinary mark, never as a violation pulse.
    is_v     = sym_nz & ~los_q & (sym_pos == last_pol);
    v_repeat = is_v & last_v_vld & (sym_pos == last_v_pol);
    zrun4    = ~sym_nz & ~los_q & (zcnt == ZW'(3));
    los_set  = ~sym_nz & ~los_q & (zcnt == Z_LOS - ZW'(1));
    los_exit = sym_nz & los_q;
  end

  // HDB3 decode, violation checks and LOS tracking, all advanced on the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_sr      <= '0;
      zcnt        <= '0;
      last_pol    <= 1'b0;
      last_v_pol  <= 1'b0;
      last_v_vld  <= 1'b0;
      los_q       <= 1'b1;
      bit_data_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      cv_err_q    <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      cv_err_q    <= 1'b0;
      if (strobe) begin
        // Output is the entry shifted out, so a V can still cancel the three symbols behind it.
        bit_data_q  <= sym_sr[3];
        bit_valid_q <= ~los_q & ~los_set;
        cv_err_q    <= sym_both | v_repeat | zrun4;
        if (los_exit)  sym_sr <= 4'b0001;
        else if (is_v) sym_sr <= 4'b0000;   // 000V and B00V both collapse to zeros
        else           sym_sr <= {sym_sr[2:0], sym_nz};
        if (sym_nz)             zcnt <= '0;
        else if (zcnt != Z_LOS) zcnt <= zcnt + ZW'(1);
        if (los_exit)     los_q <= 1'b0;
        else if (los_set) los_q <= 1'b1;
        if (sym_nz) last_pol <= sym_pos;
        if (los_exit) begin
          last_v_vld <= 1'b0;
        end else if (is_v) begin
          last_v_vld <= 1'b1;
          last_v_pol <= sym_pos;
        end
      end
    end
  end

  // Byte assembly, MSB first; the boundary restarts at LOS exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt         <= '0;
      byte_sr      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (strobe && los_exit) begin
        bcnt <= '0;
      end else if (bit_valid_q) begin
        byte_sr <= {byte_sr[5:0], bit_data_q};
        bcnt    <= bcnt + 3'd1;
        if (bcnt == 3'd7) begin
          byte_data_q  <= {byte_sr, bit_data_q};
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  assign lif.bit_data   = bit_data_q;
  assign lif.bit_valid  = bit_valid_q;
  assign lif.byte_data  = byte_data_q;
  assign lif.byte_valid = byte_valid_q;
  assign lif.cv_err     = cv_err_q;
  assign lif.los        = los_q;

`ifdef HDB3_RX_CV_COUNT_EN
  logic [15:0] cv_count_q;

  // Saturating violation count; a clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      cv_count_q <= '0;
    else if (lif.cv_clr)                          cv_count_q <= '0;
    else if (cv_err_q && cv_count_q != 16'hFFFF)  cv_count_q <= cv_count_q + 16'd1;
  end

  assign lif.cv_count = cv_count_q;
`endif
endmodule
